// File: rtl/cmd_seq_tx_if.sv
// Byte-level bus between the command sequencer and the shared command ROM / UART.
// The master modport is the sequencer's view; the slave modport is the ROM/UART side.
interface cmd_seq_tx_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] tx_data;
    logic              trmt;
    logic              tx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_rdy;
    logic              clr_rx_rdy;
    logic [DATA_W-1:0] resp_data;
    logic              resp_vld;

    modport master (
        output rom_addr, tx_data, trmt, clr_rx_rdy, resp_data, resp_vld,
        input  rom_data, tx_done, rx_data, rx_rdy
    );

    modport slave (
        input  rom_addr, tx_data, trmt, clr_rx_rdy, resp_data, resp_vld,
        output rom_data, tx_done, rx_data, rx_rdy
    );
endinterface

// File: rtl/cmd_seq_tx.sv
// Command sequencer: streams a ROM-resident command to a UART, then waits for a
// terminated response with timeout-driven resend and bounded retries.
module cmd_seq_tx #(
    parameter int                ADDR_W    = 5,
    parameter int                LEN_W     = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESP_TERM = 8'h0A,
    parameter int unsigned       TIMEOUT   = 1000000,
    parameter int unsigned       MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              resp_rcvd,
    output logic              timeout_err,
    output logic [1:0]        retry_cnt,
    cmd_seq_tx_if.master      bus
);

    localparam int                TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : {TMR_W{1'b0}};
    localparam logic              TMR_EN    = (TIMEOUT != 0);
    localparam logic [1:0]        RETRY_LIM = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_XMIT      = 3'd2;
    localparam logic [2:0] ST_WAIT_TX   = 3'd3;
    localparam logic [2:0] ST_WAIT_RESP = 3'd4;

    logic [2:0]        state_q,       state_d;
    logic [ADDR_W-1:0] rom_addr_q,    rom_addr_d;
    logic [ADDR_W-1:0] start_q,       start_d;
    logic [LEN_W-1:0]  len_q,         len_d;
    logic [LEN_W-1:0]  rem_q,         rem_d;
    logic [TMR_W-1:0]  timer_q,       timer_d;
    logic [1:0]        retry_q,       retry_d;
    logic [DATA_W-1:0] tx_data_q,     tx_data_d;
    logic              trmt_q,        trmt_d;
    logic              busy_q,        busy_d;
    logic              resp_rcvd_q,   resp_rcvd_d;
    logic              timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] resp_data_q,   resp_data_d;
    logic              resp_vld_q,    resp_vld_d;

    logic rx_term_s;
    logic tmr_expired_s;

    assign rx_term_s     = bus.rx_rdy && (bus.rx_data == RESP_TERM);
    assign tmr_expired_s = TMR_EN && (timer_q == TMR_LAST);

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        start_d       = start_q;
        len_d         = len_q;
        rem_d         = rem_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        tx_data_d     = tx_data_q;
        busy_d        = busy_q;
        resp_data_d   = resp_data_q;
        trmt_d        = 1'b0;
        resp_rcvd_d   = 1'b0;
        timeout_err_d = 1'b0;
        resp_vld_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    start_d    = cmd_start;
                    len_d      = cmd_len;
                    rom_addr_d = cmd_start;
                    rem_d      = cmd_len;
                    retry_d    = 2'd0;
                    timer_d    = {TMR_W{1'b0}};
                    busy_d     = 1'b1;
                    state_d    = (cmd_len == {LEN_W{1'b0}}) ? ST_WAIT_RESP : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_XMIT;
            end
            ST_XMIT: begin
                tx_data_d  = bus.rom_data;
                trmt_d     = 1'b1;
                rom_addr_d = rom_addr_q + ADDR_W'(1'b1);
                rem_d      = rem_q - LEN_W'(1'b1);
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.tx_done) begin
                    if (rem_q == {LEN_W{1'b0}}) begin
                        timer_d = {TMR_W{1'b0}};
                        state_d = ST_WAIT_RESP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.rx_rdy && !rx_term_s) begin
                    resp_data_d = bus.rx_data;
                    resp_vld_d  = 1'b1;
                end else begin
                    resp_vld_d = 1'b0;
                end
                // The terminator takes precedence over a coincident timer expiry.
                if (rx_term_s) begin
                    resp_rcvd_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (tmr_expired_s) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d    = retry_q + 2'd1;
                        rom_addr_d = start_q;
                        rem_d      = len_q;
                        timer_d    = {TMR_W{1'b0}};
                        state_d    = (len_q == {LEN_W{1'b0}}) ? ST_WAIT_RESP : ST_FETCH;
                    end else begin
                        timeout_err_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end else begin
                    if (TMR_EN) begin
                        timer_d = timer_q + TMR_W'(1'b1);
                    end else begin
                        timer_d = timer_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rom_addr_q    <= {ADDR_W{1'b0}};
            start_q       <= {ADDR_W{1'b0}};
            len_q         <= {LEN_W{1'b0}};
            rem_q         <= {LEN_W{1'b0}};
            timer_q       <= {TMR_W{1'b0}};
            retry_q       <= 2'd0;
            tx_data_q     <= {DATA_W{1'b0}};
            trmt_q        <= 1'b0;
            busy_q        <= 1'b0;
            resp_rcvd_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            resp_data_q   <= {DATA_W{1'b0}};
            resp_vld_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            start_q       <= start_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            tx_data_q     <= tx_data_d;
            trmt_q        <= trmt_d;
            busy_q        <= busy_d;
            resp_rcvd_q   <= resp_rcvd_d;
            timeout_err_q <= timeout_err_d;
            resp_data_q   <= resp_data_d;
            resp_vld_q    <= resp_vld_d;
        end
    end

    assign busy           = busy_q;
    assign resp_rcvd      = resp_rcvd_q;
    assign timeout_err    = timeout_err_q;
    assign retry_cnt      = retry_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_vld   = resp_vld_q;
    // Every received byte is consumed immediately, whatever the state.
    assign bus.clr_rx_rdy = bus.rx_rdy;

endmodule
